parking_lot_controller: RTL and testbench

- Multi-gate parking-lot occupancy controller, the parametrised successor to the single-gate occupancy FSM.
- Each gate has two photo-sensors: a (outer) and b (inner). A per-gate sequence FSM decodes car entries and exits.
- A shared saturating counter tracks lot occupancy against a configured capacity and drives full/empty/error status for the top-level display and gate logic.

---
 rtl/parking_pkg.sv | 21 ++
 rtl/gate_seq_fsm.sv | 160 ++++++++++++++++
 rtl/parking_lot_controller.sv | 78 +++++++
 tb/tb_parking_lot_controller.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared gate states, sensor levels and occupancy width helper
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EN_A,
    EN_AB,
    EN_B,
    EX_B,
    EX_BA,
    EX_A
  } gate_state_t;

  localparam logic BLOCKED = 1'b1;
  localparam logic OPEN    = 1'b0;

  function automatic int occ_width(input int cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/gate_seq_fsm.sv
// rtl/gate_seq_fsm.sv - per-gate sensor synchronizer, PARKING_DEBOUNCE_EN stability filter and entry/exit sequence FSM
module gate_seq_fsm
  import parking_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter,
  output logic exit
);

  localparam logic [1:0] S_NONE = {OPEN, OPEN};
  localparam logic [1:0] S_A    = {BLOCKED, OPEN};
  localparam logic [1:0] S_B    = {OPEN, BLOCKED};
  localparam logic [1:0] S_AB   = {BLOCKED, BLOCKED};

  logic [1:0]  a_sync;
  logic [1:0]  b_sync;
  logic        a_f;
  logic        b_f;
  logic [1:0]  s;
  gate_state_t state;

  // two-flop synchronizers; the sensors are asynchronous to clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sync <= 2'b00;
      b_sync <= 2'b00;
    end else begin
      a_sync <= {a_sync[0], a};
      b_sync <= {b_sync[0], b};
    end
  end

`ifdef PARKING_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic [DBW-1:0] a_cnt;
  logic [DBW-1:0] b_cnt;
  logic           a_db;
  logic           b_db;

  // stability filter: follow the synced level only after DB_CYCLES straight cycles of disagreement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_cnt <= '0;
      b_cnt <= '0;
      a_db  <= 1'b0;
      b_db  <= 1'b0;
    end else begin
      if (a_sync[1] == a_db) begin
        a_cnt <= '0;
      end else if (a_cnt == DB_LAST) begin
        a_db  <= a_sync[1];
        a_cnt <= '0;
      end else begin
        a_cnt <= a_cnt + 1'b1;
      end
      if (b_sync[1] == b_db) begin
        b_cnt <= '0;
      end else if (b_cnt == DB_LAST) begin
        b_db  <= b_sync[1];
        b_cnt <= '0;
      end else begin
        b_cnt <= b_cnt + 1'b1;
      end
    end
  end

  assign a_f = a_db;
  assign b_f = b_db;
`else
  // keeps DB_CYCLES referenced when the filter is compiled out
  logic unused_db;
  assign unused_db = (DB_CYCLES < 2);

  assign a_f = a_sync[1];
  assign b_f = b_sync[1];
`endif

  assign s = {a_f, b_f};

  // sequence decoder; enter/exit are registered and last exactly one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      enter <= 1'b0;
      exit  <= 1'b0;
    end else begin
      enter <= 1'b0;
      exit  <= 1'b0;
      case (state)
        IDLE: begin
          if (s == S_A)      state <= EN_A;
          else if (s == S_B) state <= EX_B;
        end
        EN_A: begin
          case (s)
            S_AB:   state <= EN_AB;
            S_NONE: state <= IDLE;
            S_B:    state <= IDLE;
            default: ;
          endcase
        end
        EN_AB: begin
          case (s)
            S_B:    state <= EN_B;
            S_A:    state <= EN_A;
            S_NONE: state <= IDLE;
            default: ;
          endcase
        end
        EN_B: begin
          case (s)
            S_NONE: begin
              state <= IDLE;
              enter <= 1'b1;
            end
            S_AB:   state <= EN_AB;
            S_A:    state <= IDLE;
            default: ;
          endcase
        end
        EX_B: begin
          case (s)
            S_AB:   state <= EX_BA;
            S_NONE: state <= IDLE;
            S_A:    state <= IDLE;
            default: ;
          endcase
        end
        EX_BA: begin
          case (s)
            S_A:    state <= EX_A;
            S_B:    state <= EX_B;
            S_NONE: state <= IDLE;
            default: ;
          endcase
        end
        EX_A: begin
          case (s)
            S_NONE: begin
              state <= IDLE;
              exit  <= 1'b1;
            end
            S_AB:   state <= EX_BA;
            S_B:    state <= IDLE;
            default: ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/parking_lot_controller.sv
// rtl/parking_lot_controller.sv - multi-gate occupancy counter with saturation and sticky errors; PARKING_DEBOUNCE_EN enables sensor filtering
module parking_lot_controller
  import parking_pkg::*;
#(
  parameter int N_GATES   = 2,
  parameter int CAP       = 100,
  parameter int DB_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_GATES-1:0]          a,
  input  logic [N_GATES-1:0]          b,
  input  logic                        clr_err,
  output logic [N_GATES-1:0]          enter,
  output logic [N_GATES-1:0]          exit,
  output logic [occ_width(CAP)-1:0]   occupancy,
  output logic                        full,
  output logic                        empty,
  output logic                        ovf_err,
  output logic                        udf_err
);

  localparam int OW = occ_width(CAP);
  localparam int CW = $clog2(N_GATES + 1);
  localparam int TW = OW + CW + 1;
  localparam logic signed [TW-1:0] T_CAP = TW'(CAP);

  logic [CW-1:0]        ne;
  logic [CW-1:0]        nx;
  logic signed [TW-1:0] t;
  logic                 t_over;
  logic                 t_under;

  for (genvar g = 0; g < N_GATES; g++) begin : g_gate
    gate_seq_fsm #(
      .DB_CYCLES (DB_CYCLES)
    ) u_gate (
      .clk   (clk),
      .reset (reset),
      .a     (a[g]),
      .b     (b[g]),
      .enter (enter[g]),
      .exit  (exit[g])
    );
  end

  // count this cycle's entries and exits across all gates and net them against occupancy
  always_comb begin
    ne = '0;
    nx = '0;
    for (int i = 0; i < N_GATES; i++) begin
      ne = ne + CW'(enter[i]);
      nx = nx + CW'(exit[i]);
    end
    t       = $signed(TW'(occupancy)) + $signed(TW'(ne)) - $signed(TW'(nx));
    t_over  = (t > T_CAP);
    t_under = t[TW-1];
  end

  // saturating occupancy register; a new error outranks a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
      ovf_err   <= 1'b0;
      udf_err   <= 1'b0;
    end else begin
      if (t_over)       occupancy <= OW'(CAP);
      else if (t_under) occupancy <= '0;
      else              occupancy <= t[OW-1:0];
      ovf_err <= t_over  | (ovf_err & ~clr_err);
      udf_err <= t_under | (udf_err & ~clr_err);
    end
  end

  assign full  = (occupancy == OW'(CAP));
  assign empty = (occupancy == '0);

endmodule

// File: tb/tb_parking_lot_controller.sv
// tb/tb_parking_lot_controller.sv - randomized self-checking bench for parking_lot_controller
module tb_parking_lot_controller;

  localparam int NG  = 2;
  localparam int CAP = 3;
  localparam int DB  = 4;
  localparam int OW  = $clog2(CAP + 1);
`ifdef PARKING_DEBOUNCE_EN
  localparam int EXP_LAT = 3 + DB;
`else
  localparam int EXP_LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NG-1:0] a;
  logic [NG-1:0] b;
  logic          clr_err;
  logic [NG-1:0] enter;
  logic [NG-1:0] exit;
  logic [OW-1:0] occupancy;
  logic          full;
  logic          empty;
  logic          ovf_err;
  logic          udf_err;

  int vectors     = 0;
  int miscompares = 0;
  int enter_cnt[NG] = '{default: 0};
  int exit_cnt[NG]  = '{default: 0};
  int wide_cnt      = 0;
  logic [NG-1:0] prev_en = '0;
  logic [NG-1:0] prev_ex = '0;

  int m_occ;
  bit m_ovf;
  bit m_udf;

  always #5 clk = ~clk;

  parking_lot_controller #(
    .N_GATES   (NG),
    .CAP       (CAP),
    .DB_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .clr_err   (clr_err),
    .enter     (enter),
    .exit      (exit),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .ovf_err   (ovf_err),
    .udf_err   (udf_err)
  );

  // pulse monitor: counts events per gate and any pulse longer than one cycle
  always @(negedge clk) begin
    if (reset) begin
      prev_en = '0;
      prev_ex = '0;
    end else begin
      for (int g = 0; g < NG; g++) begin
        if (enter[g]) enter_cnt[g]++;
        if (exit[g])  exit_cnt[g]++;
        if (enter[g] && prev_en[g]) wide_cnt++;
        if (exit[g] && prev_ex[g])  wide_cnt++;
      end
      prev_en = enter;
      prev_ex = exit;
    end
  end

  // lot-level model: net all events of one cycle, then clamp to 0..CAP
  function automatic void m_apply(input int ne, input int nx);
    int t;
    t = m_occ + ne - nx;
    if (t > CAP) begin
      m_occ = CAP;
      m_ovf = 1'b1;
    end else if (t < 0) begin
      m_occ = 0;
      m_udf = 1'b1;
    end else begin
      m_occ = t;
    end
  endfunction

  task automatic step(input int g, input logic [1:0] ab, input int hold);
    a[g] = ab[1];
    b[g] = ab[0];
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic [1:0] ab0, input logic [1:0] ab1, input int hold);
    a = {ab1[1], ab0[1]};
    b = {ab1[0], ab0[0]};
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (14) @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input int g, input logic [1:0] sq[$], input int hold);
    for (int i = 0; i < sq.size(); i++)
      step(g, sq[i], (hold > 0) ? hold : int'($urandom_range(5, 8)));
    settle();
  endtask

  task automatic get_seq(input int kind, output logic [1:0] sq[$], output int ne, output int nx);
    ne = 0;
    nx = 0;
    case (kind)
      0: begin sq = '{2'b10, 2'b11, 2'b01, 2'b00}; ne = 1; end
      1: begin sq = '{2'b01, 2'b11, 2'b10, 2'b00}; nx = 1; end
      2: begin sq = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00}; ne = 1; end
      3: sq = '{2'b10, 2'b11, 2'b10, 2'b00};
      4: sq = '{2'b01, 2'b11, 2'b01, 2'b00};
      6: begin sq = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00}; nx = 1; end
      default: sq = '{2'b11, 2'b00};
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1; a = '0; b = '0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (occupancy !== '0) begin miscompares++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
    vectors++; if (enter !== '0 || exit !== '0) begin miscompares++; $display("FAIL reset_pulses: got enter=%b exit=%b want 00/00", enter, exit); end
    vectors++; if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got ovf=%b udf=%b want 0/0", ovf_err, udf_err); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_occ = 0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic test_entry();
    int e0, x0, lat;
    e0 = enter_cnt[0]; x0 = exit_cnt[0]; lat = 0;
    step(0, 2'b10, 5); step(0, 2'b11, 5); step(0, 2'b01, 5);
    a[0] = 1'b0; b[0] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (enter[0]) begin lat = k; break; end
    end
    settle();
    m_apply(1, 0);
    vectors++; if (lat != EXP_LAT) begin miscompares++; $display("FAIL entry_latency: got %0d want %0d", lat, EXP_LAT); end
    vectors++; if (enter_cnt[0] - e0 != 1) begin miscompares++; $display("FAIL entry_pulses: got %0d want 1", enter_cnt[0] - e0); end
    vectors++; if (exit_cnt[0] - x0 != 0) begin miscompares++; $display("FAIL entry_no_exit: got %0d want 0", exit_cnt[0] - x0); end
    vectors++; if (occupancy !== OW'(m_occ)) begin miscompares++; $display("FAIL entry_occ: got %0d want %0d", occupancy, m_occ); end
    vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL entry_empty: got %b want 0", empty); end
  endtask

  task automatic test_exit();
    int x1;
    logic [1:0] sq[$];
    int ne, nx;
    x1 = exit_cnt[1];
    get_seq(1, sq, ne, nx);
    run_seq(1, sq, 5);
    m_apply(ne, nx);
    vectors++; if (exit_cnt[1] - x1 != 1) begin miscompares++; $display("FAIL exit_pulses: got %0d want 1", exit_cnt[1] - x1); end
    vectors++; if (occupancy !== OW'(m_occ)) begin miscompares++; $display("FAIL exit_occ: got %0d want %0d", occupancy, m_occ); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL exit_empty: got %b want 1", empty); end
  endtask

  task automatic test_reversal();
    int e0;
    logic [1:0] sq[$];
    int ne, nx;
    e0 = enter_cnt[0];
    get_seq(2, sq, ne, nx);
    run_seq(0, sq, 5);
    m_apply(ne, nx);
    vectors++; if (enter_cnt[0] - e0 != 1) begin miscompares++; $display("FAIL reversal_pulses: got %0d want 1", enter_cnt[0] - e0); end
    e0 = enter_cnt[0];
    get_seq(3, sq, ne, nx);
    run_seq(0, sq, 5);
    vectors++; if (enter_cnt[0] - e0 != 0) begin miscompares++; $display("FAIL partial_pulses: got %0d want 0", enter_cnt[0] - e0); end
    vectors++; if (occupancy !== OW'(m_occ)) begin miscompares++; $display("FAIL reversal_occ: got %0d want %0d", occupancy, m_occ); end
  endtask

  task automatic test_overflow();
    logic [1:0] sq[$];
    int ne, nx;
    get_seq(0, sq, ne, nx);
    while (m_occ < CAP) begin
      run_seq(0, sq, 5);
      m_apply(1, 0);
    end
    vectors++; if (full !== 1'b1 || ovf_err !== 1'b0) begin miscompares++; $display("FAIL preload_full: got full=%b ovf=%b want 1/0", full, ovf_err); end
    run_seq(0, sq, 5);
    m_apply(1, 0);
    vectors++; if (occupancy !== OW'(m_occ)) begin miscompares++; $display("FAIL ovf_occ: got %0d want %0d", occupancy, m_occ); end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL ovf_full: got %b want 1", full); end
    vectors++; if (ovf_err !== m_ovf) begin miscompares++; $display("FAIL ovf_flag: got %b want %b", ovf_err, m_ovf); end
    clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
    m_ovf = 1'b0;
    vectors++; if (ovf_err !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", ovf_err); end
    // clear lands in the very cycle the overflowing entry is counted
    for (int i = 0; i < 3; i++) step(0, sq[i], 5);
    a[0] = 1'b0; b[0] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (enter[0]) break;
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    settle();
    m_apply(1, 0);
    vectors++; if (ovf_err !== 1'b1) begin miscompares++; $display("FAIL ovf_wins_clear: got %b want 1", ovf_err); end
    clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [1:0] ent[$];
    logic [1:0] exs[$];
    logic [1:0] sq[$];
    int ne, nx;
    ent = '{2'b10, 2'b11, 2'b01, 2'b00};
    exs = '{2'b01, 2'b11, 2'b10, 2'b00};
    get_seq(1, sq, ne, nx);
    run_seq(1, sq, 5);
    m_apply(0, 1);
    for (int i = 0; i < 4; i++) step2(ent[i], exs[i], 5);
    settle();
    m_apply(1, 1);
    vectors++; if (occupancy !== OW'(m_occ)) begin miscompares++; $display("FAIL sim_net_occ: got %0d want %0d", occupancy, m_occ); end
    vectors++; if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin miscompares++; $display("FAIL sim_net_err: got ovf=%b udf=%b want 0/0", ovf_err, udf_err); end
    for (int i = 0; i < 4; i++) step2(ent[i], ent[i], 5);
    settle();
    m_apply(2, 0);
    vectors++; if (occupancy !== OW'(m_occ)) begin miscompares++; $display("FAIL sim_ovf_occ: got %0d want %0d", occupancy, m_occ); end
    vectors++; if (ovf_err !== m_ovf) begin miscompares++; $display("FAIL sim_ovf_flag: got %b want %b", ovf_err, m_ovf); end
    clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
    m_ovf = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) step2(exs[i], exs[i], 5);
      settle();
      m_apply(0, 2);
    end
    vectors++; if (occupancy !== OW'(m_occ) || empty !== 1'b1) begin miscompares++; $display("FAIL udf_occ: got %0d empty=%b want %0d/1", occupancy, empty, m_occ); end
    vectors++; if (udf_err !== m_udf) begin miscompares++; $display("FAIL udf_flag: got %b want %b", udf_err, m_udf); end
    clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
    m_udf = 1'b0;
    vectors++; if (udf_err !== 1'b0) begin miscompares++; $display("FAIL udf_clear: got %b want 0", udf_err); end
  endtask

  task automatic test_glitch();
    int e0, x0;
    e0 = enter_cnt[0]; x0 = exit_cnt[0];
    step(0, 2'b10, 2);
    step(0, 2'b00, 1);
    settle();
    vectors++; if (enter_cnt[0] - e0 != 0 || exit_cnt[0] - x0 != 0) begin miscompares++; $display("FAIL glitch_pulses: got %0d/%0d want 0/0", enter_cnt[0] - e0, exit_cnt[0] - x0); end
    vectors++; if (occupancy !== OW'(m_occ)) begin miscompares++; $display("FAIL glitch_occ: got %0d want %0d", occupancy, m_occ); end
  endtask

  task automatic test_random();
    logic [1:0] sq[$];
    int ne, nx, g, kind, e0, x0;
    for (int it = 0; it < 40; it++) begin
      g = int'($urandom_range(0, NG - 1));
      kind = int'($urandom_range(0, 6));
      get_seq(kind, sq, ne, nx);
      e0 = enter_cnt[g]; x0 = exit_cnt[g];
      run_seq(g, sq, 0);
      m_apply(ne, nx);
      vectors++; if (enter_cnt[g] - e0 != ne || exit_cnt[g] - x0 != nx) begin miscompares++; $display("FAIL rand_pulses it=%0d g=%0d kind=%0d: got %0d/%0d want %0d/%0d", it, g, kind, enter_cnt[g] - e0, exit_cnt[g] - x0, ne, nx); end
      vectors++; if (occupancy !== OW'(m_occ) || ovf_err !== m_ovf || udf_err !== m_udf) begin miscompares++; $display("FAIL rand_state it=%0d: got occ=%0d ovf=%b udf=%b want %0d/%b/%b", it, occupancy, ovf_err, udf_err, m_occ, m_ovf, m_udf); end
    end
    vectors++; if (wide_cnt != 0) begin miscompares++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_cnt); end
  endtask

  task automatic test_reset_mid();
    int e0, x0;
    step(0, 2'b10, 5);
    step(0, 2'b11, 5);
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (occupancy !== '0 || empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL midreset_occ: got occ=%0d empty=%b full=%b want 0/1/0", occupancy, empty, full); end
    vectors++; if (enter !== '0 || exit !== '0 || ovf_err !== 1'b0 || udf_err !== 1'b0) begin miscompares++; $display("FAIL midreset_out: got enter=%b exit=%b ovf=%b udf=%b want all 0", enter, exit, ovf_err, udf_err); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_occ = 0; m_ovf = 1'b0; m_udf = 1'b0;
    e0 = enter_cnt[0]; x0 = exit_cnt[0];
    step(0, 2'b01, 5);
    step(0, 2'b00, 5);
    settle();
    vectors++; if (enter_cnt[0] - e0 != 0 || exit_cnt[0] - x0 != 0) begin miscompares++; $display("FAIL midreset_pulses: got %0d/%0d want 0/0", enter_cnt[0] - e0, exit_cnt[0] - x0); end
    vectors++; if (occupancy !== OW'(m_occ)) begin miscompares++; $display("FAIL midreset_after_occ: got %0d want %0d", occupancy, m_occ); end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_reversal();
    test_overflow();
    test_simultaneous();
    test_glitch();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
